sync_fifo_rd_stream: RTL and testbench
======================================

Name: sync_fifo_rd_stream

Overview:
- Read-side adapter placed directly downstream of sync_fifo.
- Converts the FIFO's registered-read interface (r_en, data_out one cycle later, empty) into a first-word-fall-through valid/ready stream for the consumer.
- Holds a 3-entry prefetch buffer, so it sustains 1 word/cycle with no combinational path from m_ready to fifo_r_en.
- Provides a synchronous flush.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream payload; must match the upstream sync_fifo DATA_WIDTH.

Ports:
- clk  in  1  single clock, shared with the upstream sync_fifo.
- rstn  in  1  asynchronous active-low reset.
- fifo_empty  in  1  empty flag of the upstream FIFO.
- fifo_dout  in  DATA_WIDTH  upstream FIFO data_out; valid the cycle after an accepted read.
- fifo_r_en  out  1  read request to the upstream FIFO.
- flush  in  1  synchronous discard of all buffered and in-flight words.
- m_valid  out  1  stream payload valid.
- m_data  out  DATA_WIDTH  stream payload.
- m_ready  in  1  consumer accepts when m_valid & m_ready.
- level  out  2  number of words held in the buffer (0..3).

Behaviour:
- Reset (rstn low, async): count=0, rd_pend=0, buffer pointers=0, m_valid=0, m_data=0, level=0, fifo_r_en=0. fifo_r_en is gated low while rstn is low.
- State registers:
  - count (0..3): occupied entries.
  - rd_pend (1 bit): a read was issued last cycle.
  - 3-entry circular buffer with 2-bit head and tail pointers, each wrapping 2->0.
- Issue rule (registered terms only): fifo_r_en = rstn & ~flush & ~fifo_empty & (count + rd_pend < 3).
  - Never asserted while fifo_empty=1.
  - Never asserted while rd_pend=1 and count=2.
  - m_ready does not enter this equation.
- Read pipeline:
  - fifo_r_en high in cycle N -> rd_pend=1 in N+1.
  - fifo_dout is captured at the end of N+1 into buffer[tail], and tail advances.
  - m_valid rises in N+2. Empty-to-first-valid latency is 2 cycles.
- Output: m_valid = (count != 0); m_data = buffer[head], registered storage with no bypass from fifo_dout.
- Pop: m_valid & m_ready advances head at the clock edge. m_data must hold stable while m_valid & ~m_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. Order is strictly FIFO.
- Credit bound: count + rd_pend <= 3 at all times. The buffer never overflows, and a captured word is never dropped except by flush.
- Steady state: fifo non-empty and m_ready=1 gives count=1, rd_pend=1, fifo_r_en=1 every cycle, for full rate.
- Backpressure: with m_ready=0, issue stops once count + rd_pend = 3. The words in flight land, giving count=3, level=3.
- Flush (sampled at the edge):
  - count, head, tail and rd_pend are cleared to 0.
  - A word returning in the flush cycle is discarded.
  - fifo_r_en is 0 during the flush cycle.
  - m_valid is 0 from the next cycle.
  - Flush does not affect the upstream FIFO's contents.
- level = count.
- Reset mid-transfer behaves like flush plus an immediate asynchronous output clear.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - PREFETCH_DEPTH = 3.
  - The count/pointer width localparam (2).
  - The default DATA_WIDTH shared with sync_fifo.
- One natural sub-module: rd_prefetch_buf, the 3-entry circular storage with push/pop/clear and count.
- The top level holds the issue logic and rd_pend.

Test Plan:
- Cold start: upstream holds 0x11,0x22,0x33 with m_ready=1.
  - Required: fifo_r_en at cycles 0,1,2; m_valid from cycle 2; m_data 0x11,0x22,0x33 on consecutive cycles.
  - Required: no fifo_r_en while fifo_empty=1.
- Full-rate stream of 64 words 0x00..0x3F with m_ready=1.
  - Required: after 2-cycle latency, one word per cycle, in order, with no gaps.
- Backpressure: m_ready=0 with 8 words upstream.
  - Required: exactly 3 fifo_r_en pulses; level=3; m_data=first word, held stable.
  - Then m_ready=1: remaining words arrive in order, with no loss or duplication.
- Random m_ready (50%) over 1000 words with random upstream writes.
  - Required: scoreboard matches; count + rd_pend <= 3 always.
  - Required: m_data stable whenever m_valid & ~m_ready.
- Flush while rd_pend=1 and level=2.
  - Required: next cycle m_valid=0, level=0; the in-flight word is discarded.
  - Required: the next word delivered is the upstream word following the one in flight.
- Async reset asserted mid-stream (level=2).
  - Required: m_valid, level and fifo_r_en go to 0 immediately, without waiting for clk.
  - Required: after rstn release, normal 2-cycle-latency restart.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo family.
//   PREFETCH_DEPTH : entries in the read-side prefetch buffer
//   CNT_W          : width of prefetch count / pointers
//   DEF_DATA_WIDTH : default payload width shared with sync_fifo
//   buf_ctl_t      : push/pop/clear strobes into the prefetch buffer
//   ptr_inc()      : circular pointer increment, wraps at PREFETCH_DEPTH
package sync_fifo_pkg;

  localparam int PREFETCH_DEPTH = 3;
  localparam int CNT_W          = 2;
  localparam int DEF_DATA_WIDTH = 8;

  // Depth at count+rd_pend width, so the credit compare stays width-exact.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(PREFETCH_DEPTH);

  typedef struct packed {
    logic push;
    logic pop;
    logic clr;
  } buf_ctl_t;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(PREFETCH_DEPTH-1)) ? '0 : p + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// 3-entry circular prefetch buffer.
//   clk, rstn : clock, async active-low reset
//   ctl       : push (write wdata at tail), pop (advance head), clr (empty it)
//   wdata     : word to store on push
//   rdata     : word at head, straight from storage
//   count     : occupied entries 0..3
// clr wins over push/pop. The producer guarantees no push when full and
// no pop when empty.
module rd_prefetch_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  buf_ctl_t              ctl,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_W-1:0]      count
);

  logic [PREFETCH_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [CNT_W-1:0]                          head, tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (ctl.clr) begin
      // storage is left as-is; only the occupancy state is discarded
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (ctl.push) begin
        mem[tail] <= wdata;
        tail      <= ptr_inc(tail);
      end
      if (ctl.pop) head <= ptr_inc(head);
      if (ctl.push && !ctl.pop)      count <= count + CNT_W'(1);
      else if (!ctl.push && ctl.pop) count <= count - CNT_W'(1);
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Read-side adapter for sync_fifo: turns the registered-read interface into
// a first-word-fall-through valid/ready stream with a 3-entry prefetch.
//   clk, rstn  : clock shared with sync_fifo, async active-low reset
//   fifo_empty : upstream empty flag
//   fifo_dout  : upstream data, valid the cycle after an accepted read
//   fifo_r_en  : upstream read request
//   flush      : synchronous discard of buffered and in-flight words
//   m_valid, m_data, m_ready : output stream
//   level      : words held in the prefetch buffer
// Reads are issued on credit (count + rd_pend < depth) from registered state
// only, so m_ready never reaches fifo_r_en combinationally.
module sync_fifo_rd_stream
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      level
);

  logic             rd_pend;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit;
  buf_ctl_t         ctl;

  // words committed to the buffer: stored plus the one returning this cycle
  assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend};
  // rstn term drops the request immediately on async reset
  assign fifo_r_en = rstn & ~flush & ~fifo_empty & (credit < DEPTH_C);

  // fifo_r_en is already low under flush, so this also clears rd_pend then
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_pend <= 1'b0;
    else       rd_pend <= fifo_r_en;
  end

  // a word returning during flush is dropped by gating push
  always_comb begin
    ctl      = '0;
    ctl.clr  = flush;
    ctl.push = rd_pend & ~flush;
    ctl.pop  = m_valid & m_ready & ~flush;
  end

  rd_prefetch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .ctl   (ctl),
    .wdata (fifo_dout),
    .rdata (m_data),
    .count (count)
  );

  assign m_valid = (count != '0);
  assign level   = count;

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
module tb_sync_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = '0;
  logic       fifo_r_en;
  logic       flush = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [1:0] level;

  int total = 0;
  int bad   = 0;

  sync_fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_r_en(fifo_r_en), .flush(flush), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .level(level)
  );

  always #5 clk = ~clk;

  // upstream FIFO model: registered read, data one cycle after r_en
  logic [7:0] up_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  // reference: words the stream still owes, oldest first
  logic [7:0] exp_q [$];
  logic inflight = 1'b0;
  int   n_acc = 0;
  logic s_ren = 0, s_acc = 0, s_flush = 0;
  logic hold = 0;
  logic [7:0] hold_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    up_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // model update at the active edge using values sampled at the last negedge
  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      inflight <= 1'b0;
    end else begin
      if (s_flush) exp_q.delete();
      else begin
        if (s_acc) begin
          void'(exp_q.pop_front());
          n_acc <= n_acc + 1;
        end
        if (s_ren) exp_q.push_back(up_mem[rd_ptr]);
      end
      if (s_ren) begin
        fifo_dout <= up_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
      inflight <= s_ren;
    end
  end

  // per-cycle invariants and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rstn) begin
      s_ren <= 0; s_acc <= 0; s_flush <= 0; hold <= 0;
    end else begin
      chk("credit", ((level + inflight) <= 3), 1);
      chk("level", level, exp_q.size() - inflight);
      chk("valid", m_valid, (exp_q.size() - inflight) != 0);
      if (m_valid && exp_q.size() != 0) chk("data", m_data, exp_q[0]);
      if (fifo_empty) chk("ren_empty", fifo_r_en, 0);
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_data);
      end
      s_ren     <= fifo_r_en;
      s_acc     <= m_valid & m_ready;
      s_flush   <= flush;
      hold      <= m_valid & ~m_ready & ~flush;
      hold_data <= m_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       e_ren [6];
    logic       e_v   [6];
    logic [7:0] e_d   [6];
    int pulses, acc0, pushed, cyc;

    // reset state
    #3;
    chk("rst_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ren", fifo_r_en, 0);
    chk("rst_data", m_data, 0);
    step; step;
    rstn = 1'b1;

    // cold start: 0x11,0x22,0x33
    step;
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    e_ren = '{1, 1, 1, 0, 0, 0};
    e_v   = '{0, 0, 1, 1, 1, 0};
    e_d   = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("cold_ren%0d", i), fifo_r_en, e_ren[i]);
      chk($sformatf("cold_v%0d", i), m_valid, e_v[i]);
      if (e_v[i]) chk($sformatf("cold_d%0d", i), m_data, e_d[i]);
      step;
    end

    // full rate: 64 words, one per cycle after 2 cycles
    for (int i = 0; i < 64; i++) push(8'(i));
    @(negedge clk); step; @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      step; @(negedge clk);
      chk($sformatf("rate_v%0d", i), m_valid, 1);
      chk($sformatf("rate_d%0d", i), m_data, i);
    end
    step; @(negedge clk);
    chk("rate_end", m_valid, 0);
    step;

    // backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_r_en) pulses++;
      step;
    end
    @(negedge clk);
    chk("bp_pulses", pulses, 3);
    chk("bp_level", level, 3);
    chk("bp_data", m_data, 8'hA0);
    step;
    acc0 = n_acc;
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) step;
    chk("bp_drain", n_acc - acc0, 8);
    chk("bp_empty", level, 0);

    // random ready and upstream writes, 1000 words
    acc0 = n_acc;
    pushed = 0;
    for (cyc = 0; cyc < 20000 && (n_acc - acc0) < 1000; cyc++) begin
      step;
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom));
        pushed++;
      end
    end
    chk("rand_words", n_acc - acc0, 1000);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) step;

    // flush with rd_pend=1 and level=2
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    step; step; step;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_level", level, 2);
    chk("fl_pre_pend", inflight, 1);
    chk("fl_ren", fifo_r_en, 0);
    step;
    flush = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid", m_valid, 0);
    chk("fl_level", level, 0);
    cyc = 0;
    while (!m_valid && cyc < 10) begin step; @(negedge clk); cyc++; end
    chk("fl_latency", cyc, 2);
    chk("fl_next", m_data, 8'hC3);
    for (int i = 0; i < 6; i++) step;

    // async reset mid-stream at level=2
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    step; step; step;
    @(negedge clk);
    chk("ar_pre_level", level, 2);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", m_valid, 0);
    chk("ar_level", level, 0);
    chk("ar_ren", fifo_r_en, 0);
    step; step;
    rstn = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("ar_ren0", fifo_r_en, 1);
    chk("ar_v0", m_valid, 0);
    step; @(negedge clk);
    chk("ar_v1", m_valid, 0);
    step; @(negedge clk);
    chk("ar_v2", m_valid, 1);
    chk("ar_d2", m_data, 8'hD3);
    for (int i = 0; i < 6; i++) step;
    @(negedge clk);
    chk("final_level", level, 0);
    chk("final_empty", fifo_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
